spi_master_ncs: RTL
===================

SPI_MASTER_NCS -- requirements
Module: spi_master_ncs

Interface
REQ-001 SHALL have parameter SPI_MAXLEN, default 32, maximum bits per transaction.
REQ-002 SHALL have parameter NUM_CS, default 4, number of slave selects (>=2).
REQ-003 SHALL have parameter DIV_W, default 16, width of the runtime divider input.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 sresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 start_cmd  in  1  transaction request; cfg_*, cs_sel, n_clks and tx_data are valid and stable while high.
REQ-007 spi_drv_rdy  out  1  1 = idle and ready; 1->0 acknowledges a command; 0->1 signals completion.
REQ-008 n_clks  in  $clog2(SPI_MAXLEN)+1  number of SCLK pulses.
REQ-009 tx_data  in  SPI_MAXLEN  data to shift out on MOSI.
REQ-010 rx_miso  out  SPI_MAXLEN  data captured from MISO.
REQ-011 cfg_div  in  DIV_W  SCLK period in clk cycles.
REQ-012 cfg_cpol / cfg_cpha / cfg_lsb_first  in  1 each  SPI mode and bit order.
REQ-013 cs_sel  in  $clog2(NUM_CS)  index of the slave to select.
REQ-014 SCLK, MOSI  out  1 each; MISO  in  1; SS_N  out  NUM_CS, active-low selects.

Function
REQ-015 All cfg_*, cs_sel, n_clks and tx_data SHALL be latched on the cycle a command is accepted; later input changes SHALL have no effect.
REQ-016 Effective divider D SHALL be cfg_div with bit 0 cleared, clamped to a minimum of 4; half-period H = D/2 clk cycles.
REQ-017 Effective length N SHALL be min(n_clks, SPI_MAXLEN).
REQ-018 FSM states SHALL be IDLE, LEAD, XFER, TRAIL, GAP.
REQ-019 IDLE: a command is accepted when start_cmd=1; spi_drv_rdy SHALL be 0 from the next cycle.
REQ-020 If N=0: SS_N stays all-ones, no SCLK edge occurs, rx_miso is unchanged, and spi_drv_rdy returns to 1 after exactly one cycle low.
REQ-021 If N>0: SS_N[cs_sel] SHALL go low on the accept edge; other SS_N bits stay 1; the FSM enters LEAD for H cycles.
REQ-022 XFER SHALL produce 2N SCLK edges spaced H cycles apart; SCLK idles at cfg_cpol.
REQ-023 CPHA=0: the first bit SHALL be on MOSI at SS assertion; MISO is sampled on leading edges; MOSI shifts on trailing edges, except the final trailing edge.
REQ-024 CPHA=1: MOSI SHALL shift on leading edges; MISO is sampled on trailing edges.
REQ-025 MSB-first transmit order SHALL be tx_data[N-1] down to tx_data[0]; LSB-first order SHALL be tx_data[0] up to tx_data[N-1].
REQ-026 rx_miso SHALL be right-justified with bits [SPI_MAXLEN-1:N] = 0.
REQ-027 In MSB-first mode the first received bit SHALL land in rx_miso[N-1]; in LSB-first mode it SHALL land in rx_miso[0].
REQ-028 TRAIL SHALL hold SS_N low for H cycles after the last edge, then drive SS_N all-ones.
REQ-029 GAP SHALL keep SS_N high for H cycles, then the FSM enters IDLE with spi_drv_rdy=1.
REQ-030 rx_miso SHALL update in the same cycle spi_drv_rdy rises and SHALL hold until the next accepted command with N>0 completes.
REQ-031 MOSI SHALL be 0 whenever SS_N is all-ones.
REQ-032 If start_cmd is held high continuously, spi_drv_rdy SHALL be 1 for exactly one cycle before the next acceptance.

Reset
REQ-033 While sresetn=0, and asynchronously on its assertion, outputs SHALL be: spi_drv_rdy=1, SS_N all-ones, SCLK=0, MOSI=0, rx_miso=0, FSM=IDLE.
REQ-034 Reset mid-transaction SHALL abort immediately with no further SCLK edges.
REQ-035 After sresetn deasserts, SCLK SHALL idle at the live cfg_cpol value until the next command is accepted.

Structure
REQ-036 The FSM state enum and the mode encoding (cpol, cpha pair) SHALL be defined in shared package spi_pkg.
REQ-037 Edge timing SHALL be a sub-module spi_sclk_gen: runtime H counter emitting lead/trail edge strobes and SCLK; the shift/capture logic stays in the top module.

Verification
REQ-038 Mode 0, MSB-first, cfg_div=4, N=8, tx=0xA5, MISO looped to MOSI -> rx_miso=0x000000A5, 16 SCLK edges 2 clks apart, SS_N=4'b1110.
REQ-039 Mode 3, LSB-first, cs_sel=2, N=4, tx=0x3, MISO driven 1,0,0,0 -> MOSI sequence 1,1,0,0; rx_miso=0x1; SS_N=4'b1011; SCLK idles high.
REQ-040 cfg_div=7 and cfg_div=2 -> SCLK periods of 6 and 4 clks respectively.
REQ-041 n_clks=0 -> spi_drv_rdy low for exactly 1 cycle, no SS_N or SCLK activity; n_clks=40 with SPI_MAXLEN=32 -> exactly 32 pulses.
REQ-042 sresetn asserted at the 5th SCLK edge -> all outputs at reset values within the same cycle; a following N=8 transfer is correct.
REQ-043 start_cmd held high for 3 back-to-back N=2 transfers -> three transfers, each separated by H-cycle SS_N-high gaps plus a 1-cycle spi_drv_rdy pulse.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, SPI mode encoding and
// the divider-to-half-period helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    // Encoded as {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    localparam logic [31:0] DIV_MIN = 32'd4;

    // Even divider, never below DIV_MIN, halved into SCLK half-period clocks.
    function automatic logic [31:0] half_period(input logic [31:0] div);
        logic [31:0] d;
        d = {div[31:1], 1'b0};
        if (d < DIV_MIN) begin
            d = DIV_MIN;
        end else begin
            d = d;
        end
        return {1'b0, d[31:1]};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: half-period counter that emits leading/trailing edge strobes
// and drives the SCLK level, idling at the supplied polarity.
module spi_sclk_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             sresetn,
    input  logic             active,
    input  logic             edge_en,
    input  logic             cpol,
    input  logic [DIV_W-1:0] half,
    output logic             tick,
    output logic             lead,
    output logic             trail,
    output logic             sclk
);
    logic [DIV_W-1:0] cnt_r;
    logic             sclk_r;

    assign tick  = active && (cnt_r == (half - DIV_W'(1)));
    assign lead  = tick && edge_en && (sclk_r == cpol);
    assign trail = tick && edge_en && (sclk_r != cpol);
    assign sclk  = sclk_r;

    // Half-period counter, restarted every tick and held at zero while idle
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!active || tick) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    // SCLK level: follows polarity when idle, toggles on each edge strobe
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            sclk_r <= 1'b0;
        end else if (!active) begin
            sclk_r <= cpol;
        end else if (lead || trail) begin
            sclk_r <= ~sclk_r;
        end else begin
            sclk_r <= sclk_r;
        end
    end

endmodule

// File: rtl/spi_master_ncs.sv
// SPI master with runtime mode, bit order, divider and length, and
// NUM_CS one-hot active-low slave selects.
module spi_master_ncs
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN = 32,
    parameter int NUM_CS     = 4,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        sresetn,
    input  logic                        start_cmd,
    output logic                        spi_drv_rdy,
    input  logic [$clog2(SPI_MAXLEN):0] n_clks,
    input  logic [SPI_MAXLEN-1:0]       tx_data,
    output logic [SPI_MAXLEN-1:0]       rx_miso,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic                        cfg_cpol,
    input  logic                        cfg_cpha,
    input  logic                        cfg_lsb_first,
    input  logic [$clog2(NUM_CS)-1:0]   cs_sel,
    output logic                        SCLK,
    output logic                        MOSI,
    input  logic                        MISO,
    output logic [NUM_CS-1:0]           SS_N
);
    localparam int LEN_W = $clog2(SPI_MAXLEN) + 1;
    localparam int IDX_W = $clog2(SPI_MAXLEN);
    localparam int CNT_W = LEN_W + 1;
    localparam logic [LEN_W-1:0] MAXLEN_L = LEN_W'(SPI_MAXLEN);

    spi_state_e            state_r;
    spi_mode_e             mode_r;
    logic                  rdy_r;
    logic                  lsb_r;
    logic                  mosi_r;
    logic [NUM_CS-1:0]     ss_n_r;
    logic [DIV_W-1:0]      half_r;
    logic [LEN_W-1:0]      len_r;
    logic [LEN_W-1:0]      tx_idx_r;
    logic [LEN_W-1:0]      rx_idx_r;
    logic [CNT_W-1:0]      edge_cnt_r;
    logic [SPI_MAXLEN-1:0] tx_r;
    logic [SPI_MAXLEN-1:0] rx_sh_r;
    logic [SPI_MAXLEN-1:0] rx_r;

    logic             active_s;
    logic             edge_en_s;
    logic             cpol_s;
    logic             tick_s;
    logic             lead_s;
    logic             trail_s;
    logic             accept_s;
    logic             edge_s;
    logic             sample_s;
    logic             shift_s;
    logic             last_edge_s;
    logic [LEN_W-1:0] n_eff_s;
    logic [IDX_W-1:0] tx_pos_s;
    logic [IDX_W-1:0] rx_pos_s;
    logic [IDX_W-1:0] first_pos_s;

    assign n_eff_s     = (n_clks > MAXLEN_L) ? MAXLEN_L : n_clks;
    assign accept_s    = (state_r == ST_IDLE) && rdy_r && start_cmd;
    assign active_s    = (state_r != ST_IDLE);
    assign edge_en_s   = (state_r == ST_LEAD) || (state_r == ST_XFER);
    assign cpol_s      = active_s ? mode_r[1] : cfg_cpol;
    assign edge_s      = lead_s | trail_s;
    assign last_edge_s = (edge_cnt_r == ({len_r, 1'b0} - CNT_W'(1)));
    assign sample_s    = mode_r[0] ? trail_s : lead_s;
    // CPHA=0 launches on trailing edges, but the final trailing edge ends the word.
    assign shift_s     = mode_r[0] ? lead_s : (trail_s && !last_edge_s);

    // Sequence position k maps to bit k (LSB-first) or bit N-1-k (MSB-first).
    assign tx_pos_s    = IDX_W'(lsb_r ? tx_idx_r : (len_r - LEN_W'(1) - tx_idx_r));
    assign rx_pos_s    = IDX_W'(lsb_r ? rx_idx_r : (len_r - LEN_W'(1) - rx_idx_r));
    assign first_pos_s = IDX_W'(cfg_lsb_first ? LEN_W'(0) : (n_eff_s - LEN_W'(1)));

    assign spi_drv_rdy = rdy_r;
    assign SS_N        = ss_n_r;
    assign MOSI        = mosi_r;
    assign rx_miso     = rx_r;

    spi_sclk_gen #(
        .DIV_W (DIV_W)
    ) u_sclk_gen (
        .clk     (clk),
        .sresetn (sresetn),
        .active  (active_s),
        .edge_en (edge_en_s),
        .cpol    (cpol_s),
        .half    (half_r),
        .tick    (tick_s),
        .lead    (lead_s),
        .trail   (trail_s),
        .sclk    (SCLK)
    );

    // Transaction sequencing, ready handshake and slave select
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_r <= ST_IDLE;
            rdy_r   <= 1'b1;
            ss_n_r  <= {NUM_CS{1'b1}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rdy_r) begin
                        rdy_r <= 1'b1;
                    end else if (start_cmd) begin
                        rdy_r <= 1'b0;
                        if (n_eff_s != LEN_W'(0)) begin
                            state_r <= ST_LEAD;
                            ss_n_r  <= ~(NUM_CS'(1) << cs_sel);
                        end
                    end
                end
                ST_LEAD: begin
                    if (tick_s) state_r <= ST_XFER;
                end
                ST_XFER: begin
                    if (tick_s && last_edge_s) state_r <= ST_TRAIL;
                end
                ST_TRAIL: begin
                    if (tick_s) begin
                        ss_n_r  <= {NUM_CS{1'b1}};
                        state_r <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick_s) begin
                        state_r <= ST_IDLE;
                        rdy_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rdy_r   <= 1'b1;
                    ss_n_r  <= {NUM_CS{1'b1}};
                end
            endcase
        end
    end

    // Command latching, MOSI launch and MISO capture
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            mode_r     <= MODE0;
            lsb_r      <= 1'b0;
            half_r     <= DIV_W'(2);
            len_r      <= LEN_W'(0);
            tx_r       <= {SPI_MAXLEN{1'b0}};
            rx_sh_r    <= {SPI_MAXLEN{1'b0}};
            rx_r       <= {SPI_MAXLEN{1'b0}};
            tx_idx_r   <= LEN_W'(0);
            rx_idx_r   <= LEN_W'(0);
            edge_cnt_r <= CNT_W'(0);
            mosi_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                mode_r     <= spi_mode_e'({cfg_cpol, cfg_cpha});
                lsb_r      <= cfg_lsb_first;
                half_r     <= DIV_W'(half_period(32'(cfg_div)));
                len_r      <= n_eff_s;
                tx_r       <= tx_data;
                rx_sh_r    <= {SPI_MAXLEN{1'b0}};
                rx_idx_r   <= LEN_W'(0);
                edge_cnt_r <= CNT_W'(0);
                tx_idx_r   <= cfg_cpha ? LEN_W'(0) : LEN_W'(1);
                mosi_r     <= (cfg_cpha || (n_eff_s == LEN_W'(0))) ? 1'b0 : tx_data[first_pos_s];
            end
            if (edge_s) begin
                edge_cnt_r <= edge_cnt_r + CNT_W'(1);
            end
            if (sample_s) begin
                rx_sh_r[rx_pos_s] <= MISO;
                rx_idx_r          <= rx_idx_r + LEN_W'(1);
            end
            if (shift_s) begin
                mosi_r   <= tx_r[tx_pos_s];
                tx_idx_r <= tx_idx_r + LEN_W'(1);
            end
            if ((state_r == ST_TRAIL) && tick_s) begin
                mosi_r <= 1'b0;
            end
            if ((state_r == ST_GAP) && tick_s) begin
                rx_r <= rx_sh_r;
            end
        end
    end

endmodule
